spi_slave_rx: RTL

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/spi_slave_rx.sv
// SPI receive-only slave: synchronizes sclk/mosi/cs_n into clk, shifts MSB-first frames, one-entry output buffer.
// Latency: data_valid rises 2 clk cycles after synchronized cs_n is first seen high; frame_err/overrun are 1-cycle pulses.
// Backpressure: valid/ready output; a complete frame arriving while the buffer is full and not being drained is dropped with overrun.
module spi_slave_rx #(
    parameter int WIDTH       = 18,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             cs_n,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, cs_fall, cs_rise;
    logic [WIDTH-1:0]       shift_q;
    logic [CW-1:0]          count_q;
    logic                   deliver, accept;

    // Idle values on the synchronizers keep reset release from looking like a cs_n edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign busy      = ~cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = RECEIVE;
            RECEIVE: if (cs_rise) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bits past WIDTH only advance the counter so an over-long frame is still flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (state_q == IDLE) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (state_q == RECEIVE && sclk_rise && !cs_s) begin
            if (count_q < CNT_FULL) begin
                shift_q <= {shift_q[WIDTH-2:0], mosi_s};
            end
            if (count_q != CNT_SAT) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign deliver = (state_q == FINISH) && (count_q == CNT_FULL);
    assign accept  = data_valid && data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= (state_q == FINISH) && (count_q != CNT_FULL);
            overrun   <= deliver && data_valid && !data_ready;
            if (deliver && (!data_valid || data_ready)) begin
                data_out   <= shift_q;
                data_valid <= 1'b1;
            end else if (accept) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
